reaction_test_ctrl: RTL and testbench
=====================================

// Module: reaction_test_ctrl
// PURPOSE
//  Game sequencer for the human reaction tester. Turns the start/react buttons
//  into the 3-bit game state and a 4-digit BCD reaction time in milliseconds.
//  Both outputs feed the 4-digit seven-segment display driver.
//  Owns the random pre-stimulus delay, the stimulus LED, the false-start check and the timeout check.
// PARAMETERS
//  CLK_PER_MS   125000  clk cycles per 1 ms tick (125 MHz); >=2
//  MIN_WAIT_MS  1000    minimum random delay, ms; MIN_WAIT_MS+2047 must be <4096
//  DEB_CYCLES   250000  debounce stability window, clk cycles (DEBOUNCE_EN only)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, asynchronous, active-high
//  i_start     in   1   start button, async level, active-high
//  i_react     in   1   react button, async level, active-high
//  o_state     out  3   000 IDLE, 001 WAIT, 010 TEST, 011 DONE, 100 FAIL
//  o_time_bcd  out  16  BCD ms, [15:12] thousands .. [3:0] units
//  o_led       out  1   stimulus LED, 1 only in TEST
// BEHAVIOUR
//  Reset: clk is the only clock; rst is asynchronous, active-high.
//   rst gives o_state=000, o_time_bcd=0, o_led=0, LFSR=16'hACE1, all counters 0.
//   Asserting rst mid-game aborts the round with no further effect.
//  Inputs: each button passes a 2-flop synchronizer and then a rising-edge detector.
//   Result is a 1-cycle pulse (start_p / react_p).
//   The FSM acts on the pulse at the 3rd clk edge after the pin is sampled high.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clk, free-running.
//  ms tick: prescaler counts 0..CLK_PER_MS-1 and pulses tick when the count is CLK_PER_MS-1.
//   The prescaler clears on every state transition, so the first tick comes CLK_PER_MS cycles after entry.
//  wait_cnt is 12 bits.
//  FSM (registered; o_led = state==TEST, also registered):
//   IDLE: start_p -> WAIT; load wait_cnt = MIN_WAIT_MS + lfsr[10:0] (current LFSR value).
//   WAIT: react_p -> FAIL (false start); react_p has priority over tick.
//         on tick: if wait_cnt==1 -> TEST and o_time_bcd<=0, else wait_cnt--.
//   TEST: react_p -> DONE; o_time_bcd frozen and not incremented, even on a simultaneous tick.
//         on tick with o_time_bcd==16'h9999 -> FAIL (timeout), value held.
//         otherwise on tick: BCD +1 with decimal carry (0009->0010, 0999->1000).
//   DONE: start_p -> WAIT (new round; o_time_bcd holds until TEST entry).
//   FAIL: start_p -> IDLE.
//  Ignored pulses:
//   start_p in WAIT/TEST; react_p in IDLE/DONE/FAIL.
//   A button held high produces no repeat pulse.
//  If start_p and react_p arrive in the same cycle, each state's rules above decide.
//   Example: in WAIT both together -> FAIL.
//  o_time_bcd is meaningful in TEST/DONE; in IDLE/WAIT/FAIL it holds its last value.
//   The display overrides the digits in those states.
// CONFIGURATION
//  DEBOUNCE_EN defined:
//   Each synchronized input feeds a counter that must see a stable opposite level for DEB_CYCLES consecutive clks.
//   Only then does the debounced level flip; edge detection runs on the debounced level.
//   Pulse latency grows by DEB_CYCLES; glitches shorter than DEB_CYCLES produce no pulse.
//  DEBOUNCE_EN undefined:
//   No debounce logic; edges come straight from the synchronizer output.
// TESTING (bench: CLK_PER_MS=4, MIN_WAIT_MS=3, DEB_CYCLES=8; LFSR reference model)
//  1 rst pulse mid-TEST -> o_state=000, o_time_bcd=0, o_led=0 without waiting for a clk edge.
//  2 start, react 123 ticks after o_led rises
//    -> WAIT lasts (3+lfsr[10:0]) ticks per model, then o_state=011, o_time_bcd=16'h0123.
//  3 react during WAIT -> o_state=100, o_led stays 0; then start -> 000.
//  4 no react in TEST -> BCD passes 0099->0100 and 0999->1000, reaches 9999;
//    next tick -> o_state=100 with o_time_bcd=16'h9999.
//  5 react pulse in the same cycle as a tick in TEST -> DONE, BCD not incremented.
//    Held react in DONE and start in TEST -> no state change.
//  6 DEBOUNCE_EN: 5-cycle glitch on i_start in IDLE -> stays 000;
//    12-cycle press -> WAIT, 8 cycles later than the build without DEBOUNCE_EN.

Source files
------------

// File: rtl/reaction_test_ctrl.sv
// reaction_test_ctrl
//   Game sequencer for the human reaction tester. Converts the start and
//   react buttons into a 3-bit game state plus a 4-digit BCD reaction time
//   in milliseconds; both feed the seven-segment display driver.
//   Owns the random pre-stimulus delay, the stimulus LED, the false-start
//   check and the timeout check.
//
//   Optional build macro: DEBOUNCE_EN
//     defined   - each synchronized button level must remain stable at the
//                 opposite value for DEB_CYCLES clocks before it flips; edge
//                 detection then runs on the debounced level.
//     undefined - edges are taken directly from the synchronizer output.
//
//   Button-to-FSM latency: the FSM acts on a press at the 3rd clk edge after
//   the pin is first sampled high (plus DEB_CYCLES with DEBOUNCE_EN).

module reaction_test_ctrl #(
    parameter int CLK_PER_MS  = 125000,  // clk cycles per 1 ms tick, >= 2
    parameter int MIN_WAIT_MS = 1000,    // minimum random delay in ms
    parameter int DEB_CYCLES  = 250000   // debounce window (DEBOUNCE_EN only)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_react,
    output logic [2:0]  o_state,
    output logic [15:0] o_time_bcd,
    output logic        o_led
);

    // ------------------------------------------------------------------
    // Types and local parameters
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_WAIT = 3'b001,
        S_TEST = 3'b010,
        S_DONE = 3'b011,
        S_FAIL = 3'b100
    } state_t;

    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
    localparam logic [11:0]      WAIT_MIN = 12'(MIN_WAIT_MS);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [15:0]      BCD_MAX   = 16'h9999;

    // ------------------------------------------------------------------
    // Button conditioning: synchronizer, optional debounce, edge detect
    // ------------------------------------------------------------------
    // Bit 0 is the start button, bit 1 the react button.
    logic [1:0] btn_pin;
    logic [1:0] btn_pulse;

    assign btn_pin = {i_react, i_start};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0] sync_reg;
            logic       level;
            logic       prev_reg;

            // Two-flop synchronizer for the asynchronous button level
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= 2'b00;
                end else begin
                    sync_reg <= {sync_reg[0], btn_pin[gi]};
                end
            end

`ifdef DEBOUNCE_EN
            localparam int DEB_W = $clog2(DEB_CYCLES + 1);
            localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

            logic [DEB_W-1:0] deb_cnt_reg;
            logic             deb_level_reg;

            // Debounce: flip the level only after DEB_CYCLES consecutive
            // clocks at the opposite value; any return to the current level
            // restarts the count, so short glitches never get through.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    deb_cnt_reg   <= '0;
                    deb_level_reg <= 1'b0;
                end else if (sync_reg[1] == deb_level_reg) begin
                    deb_cnt_reg   <= '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_cnt_reg   <= '0;
                    deb_level_reg <= sync_reg[1];
                end else begin
                    deb_cnt_reg   <= deb_cnt_reg + 1'b1;
                end
            end

            assign level = deb_level_reg;
`else
            assign level = sync_reg[1];
`endif

            // Previous level for rising-edge detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= level;
                end
            end

            // One-cycle pulse on the rising edge; a held button gives no repeat
            assign btn_pulse[gi] = level & ~prev_reg;
        end
    endgenerate

    logic start_p;
    logic react_p;

    assign start_p = btn_pulse[0];
    assign react_p = btn_pulse[1];

    // ------------------------------------------------------------------
    // Free-running LFSR providing the random pre-stimulus delay
    // ------------------------------------------------------------------
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    // Taps 16,14,13,11 in right-shift (Fibonacci) form: bit n of the
    // polynomial maps to lfsr_reg[16-n].
    assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

    // Shift every clock, independent of the game state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
        end
    end

    // Delay loaded on entry to WAIT, in ms ticks
    logic [11:0] wait_load;

    assign wait_load = WAIT_MIN + {1'b0, lfsr_reg[10:0]};

    // ------------------------------------------------------------------
    // BCD incrementer (+1 with decimal carry across the four digits)
    // ------------------------------------------------------------------
    logic [15:0] time_bcd_reg;
    logic [15:0] bcd_inc;
    logic [3:0]  bcd_carry;

    assign bcd_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            logic [3:0] digit;
            logic       is_nine;

            assign digit   = time_bcd_reg[gi*4 +: 4];
            assign is_nine = (digit == 4'd9);

            assign bcd_inc[gi*4 +: 4] = !bcd_carry[gi] ? digit :
                                        (is_nine ? 4'd0 : digit + 4'd1);

            if (gi < 3) begin : g_carry
                assign bcd_carry[gi+1] = bcd_carry[gi] & is_nine;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Game FSM with ms prescaler, delay counter and reaction timer
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [PRE_W-1:0] pre_reg;
    logic             tick;
    logic [11:0]      wait_cnt_reg;
    logic             led_reg;

    assign tick = (pre_reg == PRE_LAST);

    // Single registered FSM; every state change also restarts the ms
    // prescaler so the first tick in a new state lands a full ms after entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            pre_reg      <= '0;
            wait_cnt_reg <= '0;
            time_bcd_reg <= '0;
            led_reg      <= 1'b0;
        end else begin
            pre_reg <= tick ? '0 : pre_reg + 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (start_p) begin
                        state_reg    <= S_WAIT;
                        wait_cnt_reg <= wait_load;
                        pre_reg      <= '0;
                    end
                end

                S_WAIT: begin
                    // A react press here is a false start and beats the tick
                    if (react_p) begin
                        state_reg <= S_FAIL;
                        pre_reg   <= '0;
                    end else if (tick) begin
                        if (wait_cnt_reg == 12'd1) begin
                            state_reg    <= S_TEST;
                            time_bcd_reg <= '0;
                            led_reg      <= 1'b1;
                            pre_reg      <= '0;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - 12'd1;
                        end
                    end
                end

                S_TEST: begin
                    // React freezes the time; a coincident tick is dropped
                    if (react_p) begin
                        state_reg <= S_DONE;
                        led_reg   <= 1'b0;
                        pre_reg   <= '0;
                    end else if (tick) begin
                        if (time_bcd_reg == BCD_MAX) begin
                            state_reg <= S_FAIL;
                            led_reg   <= 1'b0;
                            pre_reg   <= '0;
                        end else begin
                            time_bcd_reg <= bcd_inc;
                        end
                    end
                end

                S_DONE: begin
                    // New round; the last time stays on display until TEST
                    if (start_p) begin
                        state_reg    <= S_WAIT;
                        wait_cnt_reg <= wait_load;
                        pre_reg      <= '0;
                    end
                end

                S_FAIL: begin
                    if (start_p) begin
                        state_reg <= S_IDLE;
                        pre_reg   <= '0;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    led_reg   <= 1'b0;
                    pre_reg   <= '0;
                end
            endcase
        end
    end

    assign o_state    = state_reg;
    assign o_time_bcd = time_bcd_reg;
    assign o_led      = led_reg;

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// tb_reaction_test_ctrl
//   Directed bench for reaction_test_ctrl (CLK_PER_MS=4, MIN_WAIT_MS=3,
//   DEB_CYCLES=8). Timing is tracked with an absolute clock-edge counter and
//   an LFSR reference model predicts the random WAIT length.

module tb_reaction_test_ctrl;

    localparam int CPM = 4;
    localparam int MIN = 3;
    localparam int DEB = 8;
`ifdef DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    localparam logic [15:0] ST_IDLE = 16'd0;
    localparam logic [15:0] ST_WAIT = 16'd1;
    localparam logic [15:0] ST_TEST = 16'd2;
    localparam logic [15:0] ST_DONE = 16'd3;
    localparam logic [15:0] ST_FAIL = 16'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_react = 1'b0;
    logic [2:0]  o_state;
    logic [15:0] o_time_bcd;
    logic        o_led;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] lfsr_m;
    logic [15:0] seed;
    int          e;
    int          a;
    int          t;
    int          n;
    int          g;

    reaction_test_ctrl #(
        .CLK_PER_MS (CPM),
        .MIN_WAIT_MS(MIN),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_react   (i_react),
        .o_state   (o_state),
        .o_time_bcd(o_time_bcd),
        .o_led     (o_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: seed ACE1, taps 16,14,13,11, right-shift form
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise a button at a negedge; returns just after the edge where the FSM
    // acts on it, with seed = LFSR value the DUT sees at that edge.
    task automatic press(input bit is_react, output int act);
        @(negedge clk);
        if (is_react) i_react = 1'b1;
        else          i_start = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        seed = lfsr_m;
        @(posedge clk);
        #1;
        act = cyc;
    endtask

    task automatic release_btns();
        @(negedge clk);
        i_start = 1'b0;
        i_react = 1'b0;
    endtask

    task automatic settle();
        repeat (DEB + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset (asynchronous) ----------------
        #2 rst = 1'b1;
        #1;
        chk("rst_state", {13'd0, o_state}, ST_IDLE);
        chk("rst_bcd", o_time_bcd, 16'h0000);
        chk("rst_led", {15'd0, o_led}, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        settle();
        chk("idle_after_rst", {13'd0, o_state}, ST_IDLE);
        $display("step reset: state=%0d bcd=%h led=%0d", o_state, o_time_bcd, o_led);

        // ---------------- normal round, react after 123 ms ----------------
        press(1'b0, e);
        chk("t2_wait", {13'd0, o_state}, ST_WAIT);
        chk("t2_wait_led", {15'd0, o_led}, 16'd0);
        n = MIN + int'(seed[10:0]);
        t = e + CPM * n;
        $display("step start: seed=%h wait_ticks=%0d", seed, n);
        release_btns();
        wait_until(t - 1);
        chk("t2_wait_end", {13'd0, o_state}, ST_WAIT);
        chk("t2_wait_end_led", {15'd0, o_led}, 16'd0);
        wait_until(t);
        chk("t2_test", {13'd0, o_state}, ST_TEST);
        chk("t2_test_led", {15'd0, o_led}, 16'd1);
        chk("t2_test_bcd0", o_time_bcd, 16'h0000);
        wait_until(t + 123 * CPM + 2 - LAT);
        @(negedge clk) i_react = 1'b1;
        wait_until(t + 123 * CPM + 1);
        chk("t2_pre_react", {13'd0, o_state}, ST_TEST);
        chk("t2_pre_react_bcd", o_time_bcd, 16'h0123);
        wait_until(t + 123 * CPM + 2);
        chk("t2_done", {13'd0, o_state}, ST_DONE);
        chk("t2_done_bcd", o_time_bcd, 16'h0123);
        chk("t2_done_led", {15'd0, o_led}, 16'd0);
        $display("step react: state=%0d bcd=%h", o_state, o_time_bcd);
        // react still held in DONE: nothing may change
        wait_until(t + 123 * CPM + 42);
        chk("t5_held_react_done", {13'd0, o_state}, ST_DONE);
        chk("t5_held_react_bcd", o_time_bcd, 16'h0123);
        release_btns();
        settle();

        // ---------------- DONE -> WAIT, start in TEST, react on a tick ----------------
        press(1'b0, e);
        chk("t5_wait", {13'd0, o_state}, ST_WAIT);
        chk("t5_wait_bcd_hold", o_time_bcd, 16'h0123);
        n = MIN + int'(seed[10:0]);
        t = e + CPM * n;
        $display("step restart: seed=%h wait_ticks=%0d", seed, n);
        release_btns();
        wait_until(t);
        chk("t5_test", {13'd0, o_state}, ST_TEST);
        chk("t5_test_bcd0", o_time_bcd, 16'h0000);
        wait_until(t + 4);
        press(1'b0, a);
        chk("t5_start_in_test", {13'd0, o_state}, ST_TEST);
        chk("t5_start_in_test_led", {15'd0, o_led}, 16'd1);
        release_btns();
        wait_until(t + 20 * CPM - LAT);
        @(negedge clk) i_react = 1'b1;
        wait_until(t + 20 * CPM - 1);
        chk("t5_pre_tick", {13'd0, o_state}, ST_TEST);
        chk("t5_pre_tick_bcd", o_time_bcd, 16'h0019);
        wait_until(t + 20 * CPM);
        chk("t5_react_on_tick", {13'd0, o_state}, ST_DONE);
        chk("t5_react_on_tick_bcd", o_time_bcd, 16'h0019);
        $display("step react_on_tick: state=%0d bcd=%h", o_state, o_time_bcd);
        release_btns();
        settle();

        // ---------------- false start ----------------
        press(1'b0, e);
        chk("t3_wait", {13'd0, o_state}, ST_WAIT);
        press(1'b1, a);
        chk("t3_false_start", {13'd0, o_state}, ST_FAIL);
        chk("t3_false_start_led", {15'd0, o_led}, 16'd0);
        $display("step false_start: state=%0d led=%0d", o_state, o_led);
        release_btns();
        settle();
        press(1'b0, e);
        chk("t3_fail_to_idle", {13'd0, o_state}, ST_IDLE);
        release_btns();
        settle();

        // ---------------- timeout ----------------
        press(1'b0, e);
        chk("t4_wait", {13'd0, o_state}, ST_WAIT);
        n = MIN + int'(seed[10:0]);
        t = e + CPM * n;
        $display("step timeout_round: seed=%h wait_ticks=%0d", seed, n);
        release_btns();
        wait_until(t);
        chk("t4_test", {13'd0, o_state}, ST_TEST);
        wait_until(t + 99 * CPM);
        chk("t4_bcd_0099", o_time_bcd, 16'h0099);
        wait_until(t + 100 * CPM);
        chk("t4_bcd_0100", o_time_bcd, 16'h0100);
        wait_until(t + 999 * CPM);
        chk("t4_bcd_0999", o_time_bcd, 16'h0999);
        wait_until(t + 1000 * CPM);
        chk("t4_bcd_1000", o_time_bcd, 16'h1000);
        wait_until(t + 10000 * CPM - 1);
        chk("t4_bcd_9999", o_time_bcd, 16'h9999);
        chk("t4_still_test", {13'd0, o_state}, ST_TEST);
        wait_until(t + 10000 * CPM);
        chk("t4_timeout", {13'd0, o_state}, ST_FAIL);
        chk("t4_timeout_bcd", o_time_bcd, 16'h9999);
        chk("t4_timeout_led", {15'd0, o_led}, 16'd0);
        wait_until(t + 10002 * CPM);
        chk("t4_timeout_hold_bcd", o_time_bcd, 16'h9999);
        $display("step timeout: state=%0d bcd=%h", o_state, o_time_bcd);

        // ---------------- async reset mid-TEST ----------------
        press(1'b0, e);
        chk("t1_fail_to_idle", {13'd0, o_state}, ST_IDLE);
        release_btns();
        settle();
        press(1'b0, e);
        n = MIN + int'(seed[10:0]);
        t = e + CPM * n;
        release_btns();
        wait_until(t + 5 * CPM + 1);
        chk("t1_test_bcd5", o_time_bcd, 16'h0005);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_state", {13'd0, o_state}, ST_IDLE);
        chk("t1_rst_bcd", o_time_bcd, 16'h0000);
        chk("t1_rst_led", {15'd0, o_led}, 16'd0);
        @(negedge clk) rst = 1'b0;
        settle();
        chk("t1_idle_after", {13'd0, o_state}, ST_IDLE);
        $display("step mid_test_reset: state=%0d bcd=%h led=%0d", o_state, o_time_bcd, o_led);

        // ---------------- press latency / glitch rejection ----------------
`ifdef DEBOUNCE_EN
        @(negedge clk) i_start = 1'b1;
        repeat (5) @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_glitch_ignored", {13'd0, o_state}, ST_IDLE);
        $display("step glitch: state=%0d", o_state);
`endif
        @(negedge clk);
        i_start = 1'b1;
        g = cyc;
        wait_until(g + LAT - 1);
        chk("t6_before_act", {13'd0, o_state}, ST_IDLE);
        wait_until(g + LAT);
        chk("t6_act", {13'd0, o_state}, ST_WAIT);
        wait_until(g + 12);
        @(negedge clk) i_start = 1'b0;
        $display("step press_latency: latency=%0d state=%0d", LAT, o_state);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
